// File: rtl/ser2parallel_rx.sv
// Serial-to-parallel receiver: assembles a DATA_WIDTH-bit word from ser_in,
// one bit per en-qualified clock inside a start-framed transfer, and
// presents it on data_out with a one-cycle data_valid strobe.
module ser2parallel_rx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  input  logic                  ser_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  data_valid_d;
  logic                  overrun_d;

  // busy comes straight from the state flop, so it is registered
  assign busy = (state_q == SHIFT);

  // Shift register contents after sampling the current ser_in
  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {shift_q[DATA_WIDTH-2:0], ser_in};
    end else begin
      shifted = {ser_in, shift_q[DATA_WIDTH-1:1]};
    end
  end

  // Next-state and datapath decisions; completion takes priority over abort
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out;
    data_valid_d = 1'b0;
    overrun_d    = overrun & ~clr_err;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      SHIFT: begin
        if (en && (bit_cnt_q == LAST_BIT)) begin
          // A start landing on the completion edge opens the next frame
          // without counting as an abort.
          data_out_d   = shifted;
          data_valid_d = 1'b1;
          bit_cnt_d    = '0;
          shift_d      = '0;
          state_d      = start ? SHIFT : IDLE;
        end else if (start) begin
          overrun_d = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (en) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_ser2parallel_rx.sv
// Self-checking bench for ser2parallel_rx: a 32-bit MSB-first instance and a
// 16-bit LSB-first instance, with a scoreboard queue per instance.
module tb_ser2parallel_rx;

  logic clk = 1'b0;
  logic rst;

  logic        a_start, a_en, a_ser, a_clr;
  logic [31:0] a_dout;
  logic        a_dv, a_busy, a_ovr;

  logic        b_start, b_en, b_ser, b_clr;
  logic [15:0] b_dout;
  logic        b_dv, b_busy, b_ovr;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] qa[$];
  logic [15:0] qb[$];
  logic [31:0] ea;
  logic [15:0] eb;

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp;
    int unsigned max_gap;
  } vec_t;

  vec_t vecs[5];

  ser2parallel_rx #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .en(a_en), .ser_in(a_ser),
    .clr_err(a_clr), .data_out(a_dout), .data_valid(a_dv), .busy(a_busy),
    .overrun(a_ovr)
  );

  ser2parallel_rx #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .en(b_en), .ser_in(b_ser),
    .clr_err(b_clr), .data_out(b_dout), .data_valid(b_dv), .busy(b_busy),
    .overrun(b_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every data_valid must match the oldest pending expectation
  always @(negedge clk) begin
    if (a_dv === 1'b1) begin
      if (qa.size() == 0) check("a_spurious_valid", 64'(a_dout), 64'hDEAD_0000);
      else begin
        ea = qa.pop_front();
        check("a_data_out", 64'(a_dout), 64'(ea));
      end
    end
    if (b_dv === 1'b1) begin
      if (qb.size() == 0) check("b_spurious_valid", 64'(b_dout), 64'hDEAD_0000);
      else begin
        eb = qb.pop_front();
        check("b_data_out", 64'(b_dout), 64'(eb));
      end
    end
  end

  // Send n qualified random bits on instance A (partial frame)
  task automatic a_bits(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      a_en  = 1'b1;
      a_ser = 1'($urandom);
      tick();
    end
    a_en = 1'b0;
  endtask

  // Full 32-bit MSB-first frame on instance A with optional random en gaps
  task automatic a_frame(input logic [31:0] word, input logic [31:0] exp,
                         input int unsigned max_gap, input bit do_start,
                         input bit start_last);
    if (do_start) begin
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("a_busy_after_start", 64'(a_busy), 64'd1);
    end
    for (int i = 31; i >= 0; i--) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          a_en  = 1'b0;
          a_ser = 1'($urandom);
          tick();
          check("a_busy_in_gap", 64'(a_busy), 64'd1);
        end
      end
      a_en  = 1'b1;
      a_ser = word[i];
      if (i == 0) begin
        qa.push_back(exp);
        if (start_last) a_start = 1'b1;
      end
      tick();
    end
    a_en    = 1'b0;
    a_start = 1'b0;
    check("a_busy_after_last", 64'(a_busy), start_last ? 64'd1 : 64'd0);
  endtask

  // Full 16-bit LSB-first frame on instance B
  task automatic b_frame(input logic [15:0] word);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_en  = 1'b1;
      b_ser = word[i];
      if (i == 15) qb.push_back(word);
      tick();
    end
    b_en = 1'b0;
    check("b_busy_after_last", 64'(b_busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{word: 32'hA5A50F3C, exp: 32'hA5A50F3C, max_gap: 0};
    vecs[1] = '{word: 32'hA5A50F3C, exp: 32'hA5A50F3C, max_gap: 5};
    vecs[2] = '{word: 32'hFFFFFFFF, exp: 32'hFFFFFFFF, max_gap: 1};
    vecs[3] = '{word: 32'h00000000, exp: 32'h00000000, max_gap: 0};
    vecs[4] = '{word: 32'h80000001, exp: 32'h80000001, max_gap: 3};

    rst = 1'b1;
    a_start = 1'b0; a_en = 1'b0; a_ser = 1'b0; a_clr = 1'b0;
    b_start = 1'b0; b_en = 1'b0; b_ser = 1'b0; b_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_a_dout", 64'(a_dout), 64'd0);
    check("rst_a_dv", 64'(a_dv), 64'd0);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_ovr", 64'(a_ovr), 64'd0);
    check("rst_b_dout", 64'(b_dout), 64'd0);

    // en is ignored while idle
    a_bits(3);
    check("idle_en_busy", 64'(a_busy), 64'd0);

    // Table-driven frames, contiguous and gapped
    for (int unsigned k = 0; k < 5; k++) begin
      a_frame(vecs[k].word, vecs[k].exp, vecs[k].max_gap, 1'b1, 1'b0);
      tick();
      check("a_ovr_after_frame", 64'(a_ovr), 64'd0);
    end

    // LSB-first, 16-bit
    b_frame(16'h0001);
    tick();
    b_frame(16'hF00D);
    tick();
    check("b_ovr", 64'(b_ovr), 64'd0);

    // Abort after 10 bits, then a full frame
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_bits(10);
    a_frame(32'h12345678, 32'h12345678, 0, 1'b1, 1'b0);
    check("abort_ovr_set", 64'(a_ovr), 64'd1);
    check("abort_dout", 64'(a_dout), 64'h12345678);
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    check("clr_err_ovr", 64'(a_ovr), 64'd0);

    // clr_err coincident with an abort: abort wins
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_bits(3);
    a_start = 1'b1; a_clr = 1'b1; tick(); a_start = 1'b0; a_clr = 1'b0;
    check("clr_vs_abort_ovr", 64'(a_ovr), 64'd1);
    check("abort_restart_busy", 64'(a_busy), 64'd1);
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    check("clr_err_ovr2", 64'(a_ovr), 64'd0);
    a_frame(32'h0F0F_1234, 32'h0F0F_1234, 0, 1'b0, 1'b0);

    // Back-to-back: start coincides with the final bit of the first word
    tick();
    a_frame(32'hDEADBEEF, 32'hDEADBEEF, 0, 1'b1, 1'b1);
    check("b2b_ovr_mid", 64'(a_ovr), 64'd0);
    a_frame(32'h00000001, 32'h00000001, 0, 1'b0, 1'b0);
    tick();
    check("b2b_ovr_end", 64'(a_ovr), 64'd0);

    // Reset mid-frame clears a pending overrun and the held output
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_bits(5);
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("pre_rst_ovr", 64'(a_ovr), 64'd1);
    a_bits(20);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_dout", 64'(a_dout), 64'd0);
    check("midrst_busy", 64'(a_busy), 64'd0);
    check("midrst_ovr", 64'(a_ovr), 64'd0);
    check("midrst_dv", 64'(a_dv), 64'd0);
    a_frame(32'hCAFEF00D, 32'hCAFEF00D, 0, 1'b1, 1'b0);
    tick();
    check("post_rst_dout", 64'(a_dout), 64'hCAFEF00D);
    check("post_rst_ovr", 64'(a_ovr), 64'd0);

    tick();
    tick();
    check("qa_drained", 64'(qa.size()), 64'd0);
    check("qb_drained", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ser2parallel_rx.md
Name: ser2parallel_rx

Overview:
Serial-to-parallel receiver for the LTC2500 controller path. It captures a fixed-length serial word from the converter's serial data line, one bit per qualified clock. It then presents the assembled word on a parallel output with a one-cycle valid strobe. It is the receive-side counterpart of the controller's parallel-to-serial shifter and shares its DATA_WIDTH and its load/enable framing semantics.

Parameters:
DATA_WIDTH, 32, bits per frame; legal range 2..64.
MSB_FIRST, 1, 1 = first received bit lands in data_out[DATA_WIDTH-1]; 0 = first received bit lands in data_out[0].

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  frame start strobe, sampled on clk; begins a new frame.
en  input  1  bit qualifier; ser_in is sampled only on edges where en=1 and a frame is active.
ser_in  input  1  serial data in.
clr_err  input  1  synchronous clear of the sticky overrun flag.
data_out  output  DATA_WIDTH  last completed frame, held until the next completion.
data_valid  output  1  one-cycle pulse: data_out updated this cycle.
busy  output  1  high while a frame is being received (state SHIFT).
overrun  output  1  sticky flag: a frame was aborted by start before completion.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, bit_cnt=0, shift_reg=0, data_out=0, data_valid=0, busy=0, overrun=0. rst overrides start, en and clr_err in the same cycle. Reset mid-frame discards the partial frame without setting overrun.
- States: IDLE and SHIFT. busy = (state==SHIFT), registered.
- IDLE: start=1 moves to SHIFT, sets bit_cnt=0 and clears shift_reg. ser_in is NOT sampled on the start edge. en is ignored in IDLE.
- SHIFT, en=1: sample ser_in and increment bit_cnt.
  - MSB_FIRST=1: shift_reg <= {shift_reg[W-2:0], ser_in}.
  - MSB_FIRST=0: shift_reg <= {ser_in, shift_reg[W-1:1]}.
- SHIFT, en=0: hold all state. Gaps of any length are allowed.
- Completion: on the edge where en=1 and bit_cnt==DATA_WIDTH-1:
  - data_out <= the shifted value including the current ser_in.
  - data_valid=1 for exactly the following cycle.
  - bit_cnt <= 0 and state -> IDLE.
  - Latency: data_out/data_valid are visible one cycle after the edge that samples the last bit.
- start in SHIFT when the current edge is not a completion edge: abort. Partial data is discarded, data_out is unchanged, no data_valid, overrun <= 1, and the frame restarts (bit_cnt=0, shift_reg cleared, stay in SHIFT). The abort edge does not sample ser_in.
- start on a completion edge: the frame completes normally (data_valid pulses), the state goes to SHIFT with bit_cnt=0 for the new frame, and overrun is not set.
- overrun is cleared by clr_err=1 at an edge. If clr_err and a new abort occur on the same edge, the abort wins (overrun=1).
- data_valid is 0 on every cycle other than the post-completion cycle.
- bit_cnt width is clog2(DATA_WIDTH); it never exceeds DATA_WIDTH-1.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
1. Default params. Reset, start, then 32 consecutive en=1 cycles with ser_in = bits of 0xA5A50F3C MSB-first -> data_out=0xA5A50F3C and data_valid=1 for exactly one cycle, one cycle after the 32nd bit edge; busy high for 32 cycles; overrun=0.
2. Same word with en toggled 1,0,0,1,… (random gaps up to 5 cycles) -> identical data_out=0xA5A50F3C; data_valid only after the 32nd qualified bit; busy stays high across gaps.
3. MSB_FIRST=0, DATA_WIDTH=16: send 1 then fifteen 0s -> data_out=0x0001. Then send 0xF00D LSB-first -> data_out=0xF00D.
4. Abort: start, 10 bits, start again, then full word 0x12345678 -> no data_valid after the 10 bits; overrun=1; data_out=0x12345678 after the second frame. Pulse clr_err -> overrun=0 next cycle.
5. Back-to-back: assert start on the 32nd bit edge of word 0xDEADBEEF, then send 0x00000001 -> two data_valid pulses (0xDEADBEEF, then 0x00000001); overrun stays 0; busy never drops between frames.
6. rst at bit 20 of a frame, then a full frame 0xCAFEF00D -> outputs all 0 after reset, overrun=0, no spurious data_valid; then data_out=0xCAFEF00D.
